// File: rtl/adc_pack_pkg.sv
// rtl/adc_pack_pkg.sv - shared types and constants for the ADC frame packer
package adc_pack_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_TRL} state_t;

  localparam logic [15:0] SYNC_DEFAULT = 16'hEB90;
  localparam int          CNT_W        = 16;

  // Trailer layout: err always in bit 15; seq fills the rest unless a checksum byte takes [7:0]
  localparam int TRL_ERR_BIT    = 15;
  localparam int TRL_SEQ_W      = 15;
  localparam int TRL_CK_SEQ_W   = 7;
  localparam int TRL_CK_SEQ_LSB = 8;
  localparam int TRL_CK_W       = 8;

endpackage

// File: rtl/adc_pack_cksum.sv
// rtl/adc_pack_cksum.sv - 8-bit modulo-256 accumulator with clear and add-enable
module adc_pack_cksum (
  input  logic       wclk,
  input  logic       wrst_n,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum_nxt
);

  logic [7:0] acc;

  // Exposes the running sum including this cycle's add so the trailer can capture it on the same edge
  always_comb begin
    sum_nxt = acc;
    if (add_en) sum_nxt = acc + din;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)  acc <= '0;
    else if (clr) acc <= '0;
    else          acc <= sum_nxt;
  end

endmodule

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - frames ADC samples as sync header, samples, status trailer into the FIFO
// ADC_PACK_CHECKSUM_EN adds an 8-bit sample checksum to the trailer.
module adc_frame_packer
  import adc_pack_pkg::*;
#(
  parameter int          P_NBIT_ADC  = 12,
  parameter int          P_NBIT_D    = 16,
  parameter int          P_FRAME_LEN = 64,
  parameter logic [15:0] P_SYNC      = SYNC_DEFAULT
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  en,
  input  logic                  adc_vld,
  input  logic [P_NBIT_ADC-1:0] adc_data,
  input  logic                  wfull,
  output logic                  wr,
  output logic [P_NBIT_D-1:0]   wdata,
  output logic                  busy,
  output logic [CNT_W-1:0]      frm_cnt,
  output logic [CNT_W-1:0]      ovf_cnt
);

  state_t                 state;
  logic                   stg_vld;
  logic [CNT_W-1:0]       smp_cnt;
  logic [TRL_SEQ_W-1:0]   seq;
  logic                   err;
  logic                   drop;
  logic                   err_nxt;
  logic                   hdr_commit;
  logic                   data_commit;
  logic                   frame_done;
  logic [15:0]            trailer;

  assign wr = ((state == ST_HDR) || (state == ST_TRL) || ((state == ST_DATA) && stg_vld)) && !wfull;
  assign busy        = (state != ST_IDLE);
  assign drop        = (state == ST_DATA) && stg_vld && wfull;
  assign err_nxt     = err | drop;
  assign hdr_commit  = (state == ST_HDR) && !wfull;
  assign data_commit = (state == ST_DATA) && wr;
  assign frame_done  = (smp_cnt == CNT_W'(P_FRAME_LEN));

`ifdef ADC_PACK_CHECKSUM_EN
  logic [TRL_CK_W-1:0] cksum_nxt;

  adc_pack_cksum u_cksum (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .clr     (hdr_commit),
    .add_en  (data_commit),
    .din     (wdata[7:0]),
    .sum_nxt (cksum_nxt)
  );

  assign trailer = {err_nxt, seq[TRL_CK_SEQ_W-1:0], cksum_nxt};
`else
  assign trailer = {err_nxt, seq};
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state   <= ST_IDLE;
      wdata   <= '0;
      stg_vld <= 1'b0;
      smp_cnt <= '0;
      seq     <= '0;
      err     <= 1'b0;
      frm_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_HDR;
            wdata <= P_NBIT_D'(P_SYNC);
          end
        end
        ST_HDR: begin
          if (!wfull) begin
            state   <= ST_DATA;
            smp_cnt <= '0;
            err     <= 1'b0;
            stg_vld <= 1'b0;
          end
        end
        ST_DATA: begin
          if (drop) begin
            err <= 1'b1;
            if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
          end
          // The last staged word resolves in this same cycle, so the trailer sees its err/cksum effect
          if (frame_done) begin
            state   <= ST_TRL;
            stg_vld <= 1'b0;
            wdata   <= P_NBIT_D'(trailer);
          end else begin
            stg_vld <= adc_vld;
            if (adc_vld) begin
              smp_cnt <= smp_cnt + 1'b1;
              wdata   <= P_NBIT_D'(adc_data);
            end
          end
        end
        ST_TRL: begin
          if (!wfull) begin
            frm_cnt <= frm_cnt + 1'b1;
            seq     <= seq + 1'b1;
            if (en) begin
              state <= ST_HDR;
              wdata <= P_NBIT_D'(P_SYNC);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - scoreboard bench for adc_frame_packer with a 4-sample frame
module tb_adc_frame_packer;

`ifdef ADC_PACK_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        en;
  logic        adc_vld;
  logic [11:0] adc_data;
  logic        wfull;
  logic        wr;
  logic [15:0] wdata;
  logic        busy;
  logic [15:0] frm_cnt;
  logic [15:0] ovf_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  adc_frame_packer #(.P_FRAME_LEN(4)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .en       (en),
    .adc_vld  (adc_vld),
    .adc_data (adc_data),
    .wfull    (wfull),
    .wr       (wr),
    .wdata    (wdata),
    .busy     (busy),
    .frm_cnt  (frm_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  // Monitor: pops one expected word for each committed FIFO write
  always @(negedge wclk) begin
    if (wfull) chk("no_wr_while_full", {31'b0, wr}, 32'd0);
    if (wr && !wfull) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {16'b0, wdata}, 32'hFFFF_FFFF);
      end else begin
        chk("fifo_word", {16'b0, wdata}, {16'b0, exp_q.pop_front()});
      end
    end
  end

  // One 4-sample frame; drop_idx = sample presented while full (9 = none); en cleared at loop index en_off_at
  task automatic run_frame(input bit from_idle, input logic [11:0] d0, input logic [11:0] d1,
                           input logic [11:0] d2, input logic [11:0] d3, input int drop_idx,
                           input int hdr_stall, input int trl_stall, input int en_off_at,
                           input logic [15:0] trl_exp);
    logic [11:0] d [4];
    d = '{d0, d1, d2, d3};
    exp_q.push_back(16'hEB90);
    for (int j = 0; j < 4; j++) if (j != drop_idx) exp_q.push_back({4'h0, d[j]});
    exp_q.push_back(trl_exp);
    if (from_idle) begin
      en = 1'b1;
      step();
    end
    wfull   = (hdr_stall > 0);
    adc_vld = (hdr_stall > 0);
    adc_data = 12'h5A5;
    repeat (hdr_stall) step();
    wfull   = 1'b0;
    adc_vld = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == en_off_at) en = 1'b0;
      if (i < 4) begin
        adc_vld  = 1'b1;
        adc_data = d[i];
      end else begin
        adc_vld  = 1'b0;
      end
      wfull = (i == drop_idx + 1);
      step();
    end
    adc_vld = 1'b0;
    wfull   = (trl_stall > 0);
    adc_vld = (trl_stall > 0);
    repeat (trl_stall) step();
    wfull   = 1'b0;
    adc_vld = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst_n   = 1'b0;
    en       = 1'b0;
    adc_vld  = 1'b0;
    adc_data = '0;
    wfull    = 1'b0;
    step();
    step();
    chk("rst_wr", {31'b0, wr}, 32'd0);
    chk("rst_wdata", {16'b0, wdata}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_frm_cnt", {16'b0, frm_cnt}, 32'd0);
    chk("rst_ovf_cnt", {16'b0, ovf_cnt}, 32'd0);
    wrst_n = 1'b1;
    step();

    // Nominal framing
    run_frame(1'b1, 12'h001, 12'h002, 12'h003, 12'h004, 9, 0, 0, 0, CK ? 16'h000A : 16'h0000);
    chk("nom_frm_cnt", {16'b0, frm_cnt}, 32'd1);
    chk("nom_busy_idle", {31'b0, busy}, 32'd0);

    // Drop of sample 2 on full
    run_frame(1'b1, 12'h001, 12'h002, 12'h003, 12'h004, 1, 0, 0, 0, CK ? 16'h8108 : 16'h8001);
    chk("drop_ovf_cnt", {16'b0, ovf_cnt}, 32'd1);
    chk("drop_frm_cnt", {16'b0, frm_cnt}, 32'd2);

    // Header and trailer stalls of 5 cycles
    run_frame(1'b1, 12'h0A5, 12'h1FF, 12'h300, 12'hFFF, 9, 5, 5, 0, CK ? 16'h02A3 : 16'h0002);
    chk("stall_frm_cnt", {16'b0, frm_cnt}, 32'd3);

    // en drops after sample 2; busy falls right after trailer commit
    run_frame(1'b1, 12'h010, 12'h020, 12'h030, 12'h040, 9, 0, 0, 2, CK ? 16'h03A0 : 16'h0003);
    chk("endrop_busy", {31'b0, busy}, 32'd0);
    chk("endrop_frm_cnt", {16'b0, frm_cnt}, 32'd4);
    chk("endrop_ovf_cnt", {16'b0, ovf_cnt}, 32'd1);

    // Reset mid-DATA with sample 2 staged
    exp_q.push_back(16'hEB90);
    exp_q.push_back(16'h0011);
    en = 1'b1;
    step();
    step();
    adc_vld = 1'b1; adc_data = 12'h011; step();
    adc_vld = 1'b1; adc_data = 12'h022; step();
    adc_vld = 1'b0;
    wrst_n  = 1'b0;
    #1;
    chk("rstmid_wr", {31'b0, wr}, 32'd0);
    chk("rstmid_wdata", {16'b0, wdata}, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_frm_cnt", {16'b0, frm_cnt}, 32'd0);
    chk("rstmid_ovf_cnt", {16'b0, ovf_cnt}, 32'd0);
    step();
    step();
    chk("rstmid_no_trailer", exp_q.size(), 32'd0);
    wrst_n = 1'b1;

    // 129 back-to-back frames: seq wraps after 127 with checksum
    for (int f = 0; f < 129; f++) begin
      logic [14:0] fv;
      fv = 15'(f);
      run_frame(f == 0, 12'h001, 12'h002, 12'h003, 12'h004, 9, 0, 0, (f == 128) ? 0 : 5,
                CK ? {1'b0, fv[6:0], 8'h0A} : {1'b0, fv});
    end
    chk("wrap_frm_cnt", {16'b0, frm_cnt}, 32'd129);
    chk("wrap_ovf_cnt", {16'b0, ovf_cnt}, 32'd0);
    chk("wrap_busy", {31'b0, busy}, 32'd0);

    step();
    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
